// File: rtl/my_serial_to_parallel.sv
// LSB-first serial-to-parallel receiver with START framing, VALID/ACK
// handshake, sticky overrun flag and a one-cycle framing-error pulse.
module my_serial_to_parallel #(
  parameter int unsigned N = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         EN,
  input  logic         START,
  input  logic         SERIAL_IN,
  input  logic         ACK,
  output logic [N-1:0] DATAR,
  output logic         VALID,
  output logic         BUSY,
  output logic         OVERRUN,
  output logic         FRAME_ERR
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = N - 1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state_q, state_d;
  // Only the N-1 bits that survive into DATAR are stored; the incoming
  // bit supplies the top bit on the completing edge.
  logic [SW-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    datar_q, datar_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            ferr_q, ferr_d;
  logic [SW-1:0]   shifted;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      datar_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      datar_q   <= datar_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    datar_d   = datar_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ferr_d    = 1'b0;
    shifted   = (sreg_q >> 1) | (SW'(SERIAL_IN) << (SW - 1));

    if (ACK) begin
      valid_d = 1'b0;
    end

    if (EN) begin
      unique case (state_q)
        IDLE: begin
          if (START) begin
            sreg_d  = shifted;
            cnt_d   = CW'(1);
            state_d = RECV;
          end
        end
        RECV: begin
          if (START) begin
            ferr_d = 1'b1;
            sreg_d = SW'(SERIAL_IN) << (SW - 1);
            cnt_d  = CW'(1);
          end else if (cnt_q == CW'(N - 1)) begin
            datar_d = {SERIAL_IN, sreg_q};
            valid_d = 1'b1;
            if (valid_q && !ACK) begin
              overrun_d = 1'b1;
            end
            sreg_d  = shifted;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            sreg_d = shifted;
            cnt_d  = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign DATAR     = datar_q;
  assign VALID     = valid_q;
  assign BUSY      = (state_q == RECV);
  assign OVERRUN   = overrun_q;
  assign FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_my_serial_to_parallel.sv
// Scoreboard bench for my_serial_to_parallel (N=4): expected words are queued
// by the stimulus and checked by an independent monitor when a word appears.
module tb_my_serial_to_parallel;

  localparam int unsigned N = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         EN = 1'b0;
  logic         START = 1'b0;
  logic         SERIAL_IN = 1'b0;
  logic         ACK = 1'b0;
  logic [N-1:0] DATAR;
  logic         VALID;
  logic         BUSY;
  logic         OVERRUN;
  logic         FRAME_ERR;

  typedef struct packed {
    logic [N-1:0] data;
    logic         ovr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   ferr_cnt = 0;

  my_serial_to_parallel #(.N(N)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .START(START), .SERIAL_IN(SERIAL_IN),
    .ACK(ACK), .DATAR(DATAR), .VALID(VALID), .BUSY(BUSY), .OVERRUN(OVERRUN),
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic s, input logic b);
    EN = 1'b1; START = s; SERIAL_IN = b;
    tick();
    EN = 1'b0; START = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic ovr);
    for (int i = 0; i < int'(N); i++) begin
      if (i == int'(N) - 1) exp_q.push_back('{data: w, ovr: ovr});
      send_bit(i == 0, w[i]);
    end
  endtask

  task automatic ack_once();
    ACK = 1'b1; tick(); ACK = 1'b0;
  endtask

  // Monitor: a word is presented when VALID rises or DATAR changes under VALID.
  initial begin
    logic         pv;
    logic [N-1:0] pd;
    exp_t         e;
    pv = 1'b0; pd = '0;
    forever begin
      @(negedge CLK);
      if (FRAME_ERR) ferr_cnt++;
      if (VALID && (!pv || DATAR != pd)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", int'(DATAR), -1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_datar", int'(DATAR), int'(e.data));
          chk("sb_overrun", int'(OVERRUN), int'(e.ovr));
        end
      end
      pv = VALID; pd = DATAR;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] bits;
    // 1: reset then frame 4'hD with per-bit checks
    RESET = 1'b1; tick(); tick(); RESET = 1'b0;
    chk("rst_datar", int'(DATAR), 0);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_ovr", int'(OVERRUN), 0);
    chk("rst_ferr", int'(FRAME_ERR), 0);
    bits = 4'hD;
    exp_q.push_back('{data: 4'hD, ovr: 1'b0});
    for (int i = 0; i < 4; i++) begin
      send_bit(i == 0, bits[i]);
      if (i < 3) chk("s1_busy", int'(BUSY), 1);
    end
    chk("s1_busy_end", int'(BUSY), 0);
    chk("s1_valid", int'(VALID), 1);
    chk("s1_datar", int'(DATAR), 'hD);
    chk("s1_ferr", int'(FRAME_ERR), 0);

    // 3: VALID held until ACK
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s3_valid_hold", int'(VALID), 1);
    end
    ack_once();
    chk("s3_valid_cleared", int'(VALID), 0);
    chk("s3_datar_kept", int'(DATAR), 'hD);

    // 2: EN gaps with SERIAL_IN toggling
    exp_q.push_back('{data: 4'hD, ovr: 1'b0});
    for (int i = 0; i < 4; i++) begin
      send_bit(i == 0, bits[i]);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          SERIAL_IN = ~SERIAL_IN; START = (g == 1);
          tick();
          START = 1'b0;
          chk("s2_valid_gap", int'(VALID), 0);
          chk("s2_busy_gap", int'(BUSY), 1);
        end
      end
    end
    chk("s2_valid", int'(VALID), 1);
    chk("s2_datar", int'(DATAR), 'hD);
    ack_once();

    // 4: back-to-back frames without ACK -> overrun
    send_word(4'h3, 1'b0);
    send_word(4'hA, 1'b1);
    chk("s4_valid", int'(VALID), 1);
    chk("s4_ovr", int'(OVERRUN), 1);
    ack_once();
    chk("s4_valid_ack", int'(VALID), 0);
    repeat (3) tick();
    chk("s4_ovr_sticky", int'(OVERRUN), 1);

    // 5: premature START aborts a frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    chk("s5_ferr_pre", int'(FRAME_ERR), 0);
    bits = 4'hA;
    exp_q.push_back('{data: 4'hA, ovr: 1'b1});
    for (int i = 0; i < 4; i++) begin
      send_bit(i == 0, bits[i]);
      if (i == 0) chk("s5_ferr_pulse", int'(FRAME_ERR), 1);
      if (i == 1) chk("s5_ferr_clear", int'(FRAME_ERR), 0);
      if (i < 3) chk("s5_no_valid", int'(VALID), 0);
    end
    chk("s5_valid", int'(VALID), 1);
    chk("s5_datar", int'(DATAR), 'hA);
    chk("s5_ferr_count", ferr_cnt, 1);
    ack_once();

    // 6: reset mid-frame then clean frame 4'h6
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    RESET = 1'b1; tick(); RESET = 1'b0;
    chk("s6_rst_datar", int'(DATAR), 0);
    chk("s6_rst_valid", int'(VALID), 0);
    chk("s6_rst_busy", int'(BUSY), 0);
    chk("s6_rst_ovr", int'(OVERRUN), 0);
    chk("s6_rst_ferr", int'(FRAME_ERR), 0);
    send_word(4'h6, 1'b0);
    chk("s6_datar", int'(DATAR), 'h6);
    chk("s6_valid", int'(VALID), 1);
    chk("s6_ovr", int'(OVERRUN), 0);

    repeat (3) tick();
    chk("s6_ferr_count", ferr_cnt, 1);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
